spi_link_supervisor: RTL and testbench
======================================

# spi_link_supervisor

Controller that sequences the SPI temperature-sensor link. It sits between the SPI frame receiver and the board outputs. Each completed CS frame is audited for integrity, and only good frames are committed to the temperature register. The block tracks link health with an error counter and a watchdog, and drives the active-low LEDs plus a status byte that the receiver shifts back on MISO.

## Interface
Parameters:
- BITS_PER_FRAME, 8: bit count a valid frame must have.
- TEMP_HI, 30: alarm set threshold; a value strictly greater than TEMP_HI sets the alarm.
- TEMP_LO, 28: alarm clear threshold; a value strictly less than TEMP_LO clears the alarm. TEMP_LO must be ≤ TEMP_HI.
- ERR_LIMIT, 3: number of consecutive bad frames that declares the link lost.
- TIMEOUT_CYC, 25_000_000: clk_in cycles without a good frame before the link is declared lost (1 s at 25 MHz).

Ports:
- clk_in, in, 1: system clock, 25 MHz.
- rst, in, 1: asynchronous reset, active-low.
- frame_done, in, 1: one-cycle pulse from the receiver at CS deassertion.
- frame_bits, in, 4: SCK rising edges counted in the frame; saturates at 15 upstream.
- frame_data, in, 8: shifted byte, MSB first; valid with frame_done.
- temp_q, out, 8: last committed temperature.
- alarm, out, 1: over-temperature flag with hysteresis.
- link_ok, out, 1: high only in state OK.
- led, out, 2: active-low. led[0] = ~alarm; led[1] = ~link_ok.
- status_byte, out, 8: {state[1:0], alarm, last_bad, err_cnt[3:0]}.

## Operation
- States, 2-bit encoding: IDLE=00, OK=01, DEGRADED=10, LOST=11.
- Frame classification on frame_done:
  - frame_bits==0: glitch. Ignored entirely; no state, counter or watchdog change.
  - frame_bits==BITS_PER_FRAME: good frame.
  - Any other value: bad frame.
- Good frame:
  - temp_q ← frame_data.
  - Alarm update: if frame_data > TEMP_HI, alarm ← 1; else if frame_data < TEMP_LO, alarm ← 0; otherwise hold.
  - consec_err ← 0, last_bad ← 0, watchdog cleared.
  - State → OK from any state.
- Bad frame:
  - temp_q and alarm are held.
  - last_bad ← 1; consec_err increments, saturating at 15.
  - err_cnt (total, 4-bit) increments, saturating at 15; it is cleared only by reset.
  - State transitions:
    - OK → DEGRADED.
    - DEGRADED → LOST when the new consec_err ≥ ERR_LIMIT.
    - IDLE stays IDLE.
    - LOST stays LOST.
- Watchdog:
  - The counter runs in every state except IDLE and LOST and saturates at TIMEOUT_CYC.
  - Reaching TIMEOUT_CYC forces the state to LOST.
  - In LOST, alarm is forced to 1 (fail-safe: sensor unknown). It is re-evaluated by the next good frame.
- frame_done and watchdog expiry in the same cycle: the frame takes priority. A good frame moves the state to OK and clears the watchdog.

## Timing
- All outputs are registered. The effect of frame_done at cycle N is visible at cycle N+1.
- Watchdog expiry: the state reaches LOST in the cycle after the counter equals TIMEOUT_CYC. This is TIMEOUT_CYC+1 cycles after the last good frame's commit.
- Reset values:
  - state=IDLE, temp_q=0, alarm=0, last_bad=0, consec_err=0, err_cnt=0, watchdog=0.
  - Hence link_ok=0, led=2'b11, status_byte=8'h00.
- Reset is asynchronous on assertion and applies mid-frame; a frame_done during reset is lost. Deassertion is synchronized externally.
- frame_done pulses must be at least 2 cycles apart; back-to-back pulses are undefined.
- Counter width is $clog2(TIMEOUT_CYC+1). The temperature comparison is unsigned 8-bit.

## Structure
- Package spi_link_pkg holds:
  - typedef enum logic [1:0] link_state_t {IDLE, OK, DEGRADED, LOST};
  - localparam STATUS_* bit positions for status_byte.
- One sub-module, link_watchdog: a saturating counter with clear and enable inputs and an expired output, parameterized by TIMEOUT_CYC.
- The classification, state FSM and alarm hysteresis stay in spi_link_supervisor.
- Target size is approximately 200 lines of RTL.

## Test plan
All scenarios use TIMEOUT_CYC=100 and ERR_LIMIT=3 on the bench.
- Reset, then a good frame (bits=8, data=35): next cycle state=OK, temp_q=35, alarm=1, led=2'b00, status_byte=8'h60.
- After 35, send good frames 29 then 25: after 29, alarm stays 1 (hysteresis); after 25, alarm=0 and led=2'b01.
- From OK with temp_q=25, send a frame with bits=7, data=FF: temp_q stays 25, state=DEGRADED, led[1]=1, last_bad=1, err_cnt=1. Two more 7-bit frames → LOST, alarm=1. One good frame with data=20 → OK, alarm=0.
- Send a frame with bits=0: no output change. Send bits=15: counted as bad.
- Good frame, then idle for 101 cycles: state=LOST and alarm=1 at cycle 101. A good frame arriving in the same cycle as expiry → OK.
- Assert rst mid-DEGRADED with err_cnt=5: all outputs return to reset values immediately and asynchronously. After deassertion, IDLE ignores the watchdog.

Source files
------------

// File: rtl/spi_link_pkg.sv
// spi_link_pkg: shared link states and status byte layout for the SPI link supervisor
package spi_link_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, OK = 2'b01, DEGRADED = 2'b10, LOST = 2'b11} link_state_t;
  localparam int unsigned STATUS_STATE_HI = 7;
  localparam int unsigned STATUS_STATE_LO = 6;
  localparam int unsigned STATUS_ALARM = 5;
  localparam int unsigned STATUS_LAST_BAD = 4;
  localparam int unsigned STATUS_ERR_HI = 3;
  localparam int unsigned STATUS_ERR_LO = 0;
endpackage

// File: rtl/link_watchdog.sv
// link_watchdog: saturating cycle counter that flags expiry at TIMEOUT_CYC
module link_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 25_000_000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt_q, cnt_d;
  // count enabled cycles, holding at the timeout value until cleared
  always_comb cnt_d = clr_i ? '0 : (en_i && !expired_o) ? cnt_q + W'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk_in or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired_o = cnt_q == W'(TIMEOUT_CYC);
endmodule

// File: rtl/spi_link_supervisor.sv
// spi_link_supervisor: audits SPI frames, commits good temperatures and tracks link health
module spi_link_supervisor
  import spi_link_pkg::*;
#(
  parameter int unsigned BITS_PER_FRAME = 8,
  parameter int unsigned TEMP_HI = 30,
  parameter int unsigned TEMP_LO = 28,
  parameter int unsigned ERR_LIMIT = 3,
  parameter int unsigned TIMEOUT_CYC = 25_000_000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       frame_done,
  input  logic [3:0] frame_bits,
  input  logic [7:0] frame_data,
  output logic [7:0] temp_q,
  output logic       alarm,
  output logic       link_ok,
  output logic [1:0] led,
  output logic [7:0] status_byte
);
  link_state_t state_q, state_d;
  logic [7:0] temp_d;
  logic alarm_q, alarm_d, last_bad_q, last_bad_d, expired, good, bad;
  logic [3:0] consec_q, consec_d, err_q, err_d;
  assign good = frame_done && frame_bits == 4'(BITS_PER_FRAME);
  assign bad = frame_done && frame_bits != 4'd0 && !good;
  link_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk_in(clk_in),
    .rst(rst),
    .clr_i(good),
    .en_i(state_q == OK || state_q == DEGRADED),
    .expired_o(expired)
  );
  // frame classification, link FSM and alarm hysteresis; a frame outranks watchdog expiry
  always_comb begin
    state_d = state_q;
    temp_d = temp_q;
    alarm_d = alarm_q;
    last_bad_d = last_bad_q;
    consec_d = consec_q;
    err_d = err_q;
    if (good) begin
      state_d = OK;
      temp_d = frame_data;
      alarm_d = (32'(frame_data) > TEMP_HI) ? 1'b1 : (32'(frame_data) < TEMP_LO) ? 1'b0 : alarm_q;
      last_bad_d = 1'b0;
      consec_d = '0;
    end else if (bad) begin
      last_bad_d = 1'b1;
      consec_d = (consec_q == 4'hF) ? consec_q : consec_q + 4'd1;
      err_d = (err_q == 4'hF) ? err_q : err_q + 4'd1;
      state_d = (state_q == OK) ? DEGRADED :
                (state_q == DEGRADED && 32'(consec_d) >= ERR_LIMIT) ? LOST : state_q;
    end else if (expired) state_d = LOST;
    if (state_d == LOST) alarm_d = 1'b1;
  end
  // state and datapath registers
  always_ff @(posedge clk_in or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      temp_q <= '0;
      alarm_q <= 1'b0;
      last_bad_q <= 1'b0;
      consec_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      temp_q <= temp_d;
      alarm_q <= alarm_d;
      last_bad_q <= last_bad_d;
      consec_q <= consec_d;
      err_q <= err_d;
    end
  assign alarm = alarm_q;
  assign link_ok = state_q == OK;
  assign led = {~link_ok, ~alarm_q};
  assign status_byte[STATUS_STATE_HI:STATUS_STATE_LO] = state_q;
  assign status_byte[STATUS_ALARM] = alarm_q;
  assign status_byte[STATUS_LAST_BAD] = last_bad_q;
  assign status_byte[STATUS_ERR_HI:STATUS_ERR_LO] = err_q;
endmodule

// File: tb/tb_spi_link_supervisor.sv
// tb_spi_link_supervisor: directed frames with a cycle-tagged scoreboard checked by a monitor
module tb_spi_link_supervisor;
  logic clk_in = 1'b0, rst = 1'b0, frame_done = 1'b0;
  logic [3:0] frame_bits = '0;
  logic [7:0] frame_data = '0, temp_q, status_byte;
  logic alarm, link_ok;
  logic [1:0] led;
  int cycle = 0, checks = 0, failures = 0, commit = 0;
  typedef struct {int cyc; logic [7:0] t; logic [7:0] s;} exp_t;
  exp_t sb[$];

  spi_link_supervisor #(.BITS_PER_FRAME(8), .TEMP_HI(30), .TEMP_LO(28), .ERR_LIMIT(3), .TIMEOUT_CYC(100)) dut (
    .clk_in(clk_in), .rst(rst), .frame_done(frame_done), .frame_bits(frame_bits),
    .frame_data(frame_data), .temp_q(temp_q), .alarm(alarm), .link_ok(link_ok),
    .led(led), .status_byte(status_byte)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cycle <= cycle + 1;

  task automatic chk(input string name, input int c, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, c, act, exp);
    end
  endtask

  // expected status byte is hand-computed; alarm/link/led are read out of it
  task automatic push(input int c, input logic [7:0] t, input logic [7:0] s);
    sb.push_back('{c, t, s});
  endtask

  always @(negedge clk_in) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      exp_t e;
      logic lk;
      e = sb.pop_front();
      lk = e.s[7:6] == 2'b01;
      if (e.cyc < cycle) chk("missed_sample", e.cyc, cycle, e.cyc);
      else begin
        chk("temp_q", cycle, int'(temp_q), int'(e.t));
        chk("status_byte", cycle, int'(status_byte), int'(e.s));
        chk("alarm", cycle, int'(alarm), int'(e.s[5]));
        chk("link_ok", cycle, int'(link_ok), int'(lk));
        chk("led", cycle, int'(led), int'({~lk, ~e.s[5]}));
      end
    end
  end

  // issue one frame on a negedge; its effect is expected one cycle later
  task automatic send(input logic [3:0] b, input logic [7:0] d, input logic [7:0] t, input logic [7:0] s);
    frame_done = 1'b1;
    frame_bits = b;
    frame_data = d;
    commit = cycle + 1;
    push(cycle + 1, t, s);
    @(negedge clk_in);
    frame_done = 1'b0;
    frame_bits = '0;
    frame_data = '0;
    @(negedge clk_in);
  endtask

  task automatic goto(input int c);
    while (cycle < c) @(negedge clk_in);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cycle=%0d", cycle);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk_in);
    rst = 1'b1;
    push(cycle + 1, 8'd0, 8'h00);
    @(negedge clk_in);
    @(negedge clk_in);
    send(4'd8, 8'd35, 8'd35, 8'h60);
    send(4'd8, 8'd29, 8'd29, 8'h60);
    send(4'd8, 8'd25, 8'd25, 8'h40);
    send(4'd7, 8'hFF, 8'd25, 8'h91);
    send(4'd7, 8'hFF, 8'd25, 8'h92);
    send(4'd7, 8'hFF, 8'd25, 8'hF3);
    send(4'd8, 8'd20, 8'd20, 8'h43);
    send(4'd0, 8'hAA, 8'd20, 8'h43);
    send(4'd15, 8'h01, 8'd20, 8'h94);
    send(4'd8, 8'd31, 8'd31, 8'h64);
    push(commit + 100, 8'd31, 8'h64);
    push(commit + 101, 8'd31, 8'hE4);
    goto(commit + 102);
    send(4'd8, 8'd10, 8'd10, 8'h44);
    goto(commit + 100);
    send(4'd8, 8'd29, 8'd29, 8'h44);
    push(cycle + 1, 8'd29, 8'h44);
    @(negedge clk_in);
    @(negedge clk_in);
    send(4'd5, 8'h00, 8'd29, 8'h95);
    @(posedge clk_in);
    #2 rst = 1'b0;
    push(cycle, 8'd0, 8'h00);
    repeat (3) @(negedge clk_in);
    rst = 1'b1;
    repeat (150) @(negedge clk_in);
    push(cycle + 1, 8'd0, 8'h00);
    @(negedge clk_in);
    @(negedge clk_in);
    send(4'd7, 8'h00, 8'd0, 8'h11);
    repeat (3) @(negedge clk_in);
    if (sb.size() != 0) chk("scoreboard_drain", cycle, sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
